// File: rtl/mmcm_ps_sequencer.sv
// MMCM dynamic phase-shift sequencer: one psen per requested step, waits for psdone,
// spaces pulses by GAP_CYC, tracks net phase and flags timeout / lock loss.
module mmcm_ps_sequencer #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic             clk_312_50Mhz_MASTER,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_steps,
    input  logic             abort,
    input  logic             mmcm_locked,
    output logic             psen,
    output logic             psincdec,
    input  logic             psdone,
    output logic             busy,
    output logic             done_pulse,
    output logic [CNT_W-1:0] steps_issued,
    output logic [31:0]      net_phase,
    output logic             timeout_err,
    output logic             lock_err
);

    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   remaining, remaining_nxt;
    logic [TMO_W-1:0]   timer, timer_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
    logic               psen_nxt, psincdec_nxt, busy_nxt, done_nxt;
    logic               timeout_nxt, lock_nxt;
    logic [CNT_W-1:0]   steps_nxt;
    logic [31:0]        net_nxt;
    logic [CNT_W-1:0]   req_mag;

    // Magnitude as unsigned CNT_W: the most negative request maps to 2^(CNT_W-1)
    assign req_mag   = req_steps[CNT_W-1] ? (~req_steps + CNT_W'(1)) : req_steps;
    assign req_ready = (state == IDLE) && mmcm_locked && !rst;

    always_ff @(posedge clk_312_50Mhz_MASTER or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= '0;
            timer        <= '0;
            gap_cnt      <= '0;
            psen         <= 1'b0;
            psincdec     <= 1'b0;
            busy         <= 1'b0;
            done_pulse   <= 1'b0;
            steps_issued <= '0;
            net_phase    <= '0;
            timeout_err  <= 1'b0;
            lock_err     <= 1'b0;
        end else begin
            state        <= state_nxt;
            remaining    <= remaining_nxt;
            timer        <= timer_nxt;
            gap_cnt      <= gap_cnt_nxt;
            psen         <= psen_nxt;
            psincdec     <= psincdec_nxt;
            busy         <= busy_nxt;
            done_pulse   <= done_nxt;
            steps_issued <= steps_nxt;
            net_phase    <= net_nxt;
            timeout_err  <= timeout_nxt;
            lock_err     <= lock_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        timer_nxt     = timer;
        gap_cnt_nxt   = gap_cnt;
        psincdec_nxt  = psincdec;
        done_nxt      = 1'b0;
        steps_nxt     = steps_issued;
        net_nxt       = net_phase;
        timeout_nxt   = timeout_err;
        lock_nxt      = lock_err;

        case (state)
            IDLE: begin
                if (req_valid && mmcm_locked) begin
                    timeout_nxt = 1'b0;
                    lock_nxt    = 1'b0;
                    steps_nxt   = '0;
                    if (req_steps == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        remaining_nxt = req_mag;
                        psincdec_nxt  = !req_steps[CNT_W-1];
                        state_nxt     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                timer_nxt = '0;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                timer_nxt = timer + TMO_W'(1);
                // psdone takes priority over a coincident timeout
                if (psdone) begin
                    remaining_nxt = remaining - CNT_W'(1);
                    steps_nxt     = steps_issued + CNT_W'(1);
                    net_nxt       = psincdec ? (net_phase + 32'd1) : (net_phase - 32'd1);
                    if ((remaining == CNT_W'(1)) || abort) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else if (GAP_CYC == 0) begin
                        state_nxt = ISSUE;
                    end else begin
                        gap_cnt_nxt = '0;
                        state_nxt   = GAP;
                    end
                end else if (timer == TMO_W'(TIMEOUT_CYC - 1)) begin
                    timeout_nxt = 1'b1;
                    done_nxt    = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            GAP: begin
                if (abort) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                    state_nxt = ISSUE;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Lock loss abandons the request without accounting or done_pulse
        if ((state != IDLE) && !mmcm_locked) begin
            state_nxt     = IDLE;
            lock_nxt      = 1'b1;
            done_nxt      = 1'b0;
            timeout_nxt   = timeout_err;
            remaining_nxt = remaining;
            steps_nxt     = steps_issued;
            net_nxt       = net_phase;
        end

        psen_nxt = (state_nxt == ISSUE);
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_mmcm_ps_sequencer.sv
// Directed bench for mmcm_ps_sequencer with an MMCM psdone responder and a
// scoreboard of per-request end results.
module tb_mmcm_ps_sequencer;

    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [CNT_W-1:0] steps;
        logic [31:0]      net;
        logic             tmo;
        logic             lck;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [CNT_W-1:0] req_steps;
    logic             abort;
    logic             mmcm_locked;
    logic             psen;
    logic             psincdec;
    logic             psdone;
    logic             busy;
    logic             done_pulse;
    logic [CNT_W-1:0] steps_issued;
    logic [31:0]      net_phase;
    logic             timeout_err;
    logic             lock_err;

    logic resp_psdone = 1'b0;
    logic force_psdone;
    int   resp_dly;
    int   cd = 0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t exp_q[$];
    int   psen_cyc_q[$];
    logic psen_dir_q[$];

    assign psdone = resp_psdone | force_psdone;

    mmcm_ps_sequencer dut (
        .clk_312_50Mhz_MASTER(clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_steps           (req_steps),
        .abort               (abort),
        .mmcm_locked         (mmcm_locked),
        .psen                (psen),
        .psincdec            (psincdec),
        .psdone              (psdone),
        .busy                (busy),
        .done_pulse          (done_pulse),
        .steps_issued        (steps_issued),
        .net_phase           (net_phase),
        .timeout_err         (timeout_err),
        .lock_err            (lock_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // MMCM model: psdone arrives resp_dly cycles after psen; 0 means never
    always @(posedge clk) begin
        resp_psdone <= 1'b0;
        if (psen && resp_dly != 0) begin
            cd <= resp_dly - 1;
        end else if (cd != 0) begin
            cd <= cd - 1;
            if (cd == 1) resp_psdone <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (psen) begin
            psen_cyc_q.push_back(cyc);
            psen_dir_q.push_back(psincdec);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int s, input logic [31:0] n, input logic t, input logic l);
        exp_t e;
        e.steps = CNT_W'(s);
        e.net   = n;
        e.tmo   = t;
        e.lck   = l;
        exp_q.push_back(e);
    endtask

    task automatic sb_compare(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_steps"}, 64'(steps_issued), 64'(e.steps));
            chk({tag, "_net"}, 64'(net_phase), 64'(e.net));
            chk({tag, "_timeout_err"}, 64'(timeout_err), 64'(e.tmo));
            chk({tag, "_lock_err"}, 64'(lock_err), 64'(e.lck));
        end
    endtask

    task automatic send(input string tag, input int s);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 64'(req_ready), 64'd1);
        psen_cyc_q.delete();
        psen_dir_q.delete();
        req_steps = CNT_W'(s);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max, output int at_cyc);
        logic seen;
        seen   = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (done_pulse) begin
                seen   = 1'b1;
                at_cyc = cyc;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_steps(input string tag, input int target, input int max);
        int n;
        n = 0;
        while (steps_issued != CNT_W'(target) && n < max) begin
            tick();
            n++;
        end
        chk({tag, "_steps_reached"}, 64'(steps_issued), 64'(CNT_W'(target)));
    endtask

    initial begin
        logic [31:0] exp_net;
        int          dc;
        int          p;
        int          ca;
        int          n;

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_steps    = '0;
        abort        = 1'b0;
        mmcm_locked  = 1'b1;
        force_psdone = 1'b0;
        resp_dly     = 12;
        exp_net      = 32'd0;

        repeat (3) tick();
        chk("rst_psen", 64'(psen), 64'd0);
        chk("rst_psincdec", 64'(psincdec), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done_pulse), 64'd0);
        chk("rst_steps", 64'(steps_issued), 64'd0);
        chk("rst_net", 64'(net_phase), 64'd0);
        chk("rst_tmo", 64'(timeout_err), 64'd0);
        chk("rst_lock", 64'(lock_err), 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready_after", 64'(req_ready), 64'd1);

        // +3 steps, psdone 12 cycles after each psen, gap 4
        exp_net = exp_net + 32'd3;
        push_exp(3, exp_net, 1'b0, 1'b0);
        send("p3", 3);
        chk("p3_psen_first", 64'(psen), 64'd1);
        chk("p3_busy", 64'(busy), 64'd1);
        chk("p3_incdec", 64'(psincdec), 64'd1);
        wait_done("p3", 200, dc);
        chk("p3_ready_at_done", 64'(req_ready), 64'd1);
        sb_compare("p3");
        chk("p3_psen_count", 64'(psen_cyc_q.size()), 64'd3);
        if (psen_cyc_q.size() == 3) begin
            chk("p3_space1", 64'(psen_cyc_q[1] - psen_cyc_q[0]), 64'd17);
            chk("p3_space2", 64'(psen_cyc_q[2] - psen_cyc_q[1]), 64'd17);
            chk("p3_done_lat", 64'(dc - psen_cyc_q[2]), 64'd13);
            chk("p3_dirs", 64'({psen_dir_q[0], psen_dir_q[1], psen_dir_q[2]}), 64'd7);
        end
        tick();
        chk("p3_done_single", 64'(done_pulse), 64'd0);

        // -2 steps
        exp_net = exp_net - 32'd2;
        push_exp(2, exp_net, 1'b0, 1'b0);
        send("m2", -2);
        chk("m2_incdec", 64'(psincdec), 64'd0);
        wait_done("m2", 200, dc);
        sb_compare("m2");
        chk("m2_psen_count", 64'(psen_cyc_q.size()), 64'd2);

        // most negative request: four steps then abort in GAP
        send("min", -32768);
        chk("min_incdec", 64'(psincdec), 64'd0);
        wait_steps("min", 4, 200);
        abort = 1'b1;
        ca = cyc;
        exp_net = exp_net - 32'd4;
        push_exp(4, exp_net, 1'b0, 1'b0);
        wait_done("min", 20, dc);
        abort = 1'b0;
        chk("min_abort_lat", 64'(dc - ca), 64'd1);
        sb_compare("min");
        chk("min_psen_count", 64'(psen_cyc_q.size()), 64'd4);

        // abort during WAIT_DONE of step 2 of 5
        send("ab", 5);
        wait_steps("ab", 1, 100);
        n = 0;
        while (!psen && n < 20) begin
            tick();
            n++;
        end
        chk("ab_psen2_seen", 64'(psen), 64'd1);
        tick();
        abort = 1'b1;
        exp_net = exp_net + 32'd2;
        push_exp(2, exp_net, 1'b0, 1'b0);
        wait_done("ab", 50, dc);
        abort = 1'b0;
        sb_compare("ab");
        if (psen_cyc_q.size() >= 2)
            chk("ab_hold_until_psdone", 64'(dc - psen_cyc_q[1]), 64'd13);
        repeat (30) tick();
        chk("ab_no_more_psen", 64'(psen_cyc_q.size()), 64'd2);

        // timeout: psdone never returned
        resp_dly = 0;
        push_exp(0, exp_net, 1'b1, 1'b0);
        send("tmo", 1);
        wait_done("tmo", 150, dc);
        sb_compare("tmo");
        if (psen_cyc_q.size() == 1)
            chk("tmo_latency", 64'(dc - psen_cyc_q[0]), 64'd65);
        resp_dly = 12;

        // zero-step request clears the sticky timeout
        push_exp(0, exp_net, 1'b0, 1'b0);
        send("zero", 0);
        chk("zero_done", 64'(done_pulse), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        sb_compare("zero");
        tick();
        chk("zero_no_psen", 64'(psen_cyc_q.size()), 64'd0);

        // lock loss in GAP, then a spurious psdone in IDLE
        send("lk", 3);
        wait_steps("lk", 1, 100);
        mmcm_locked = 1'b0;
        tick();
        exp_net = exp_net + 32'd1;
        push_exp(1, exp_net, 1'b0, 1'b1);
        chk("lk_busy", 64'(busy), 64'd0);
        chk("lk_no_done", 64'(done_pulse), 64'd0);
        chk("lk_ready_low", 64'(req_ready), 64'd0);
        sb_compare("lk");
        force_psdone = 1'b1;
        tick();
        force_psdone = 1'b0;
        repeat (5) tick();
        chk("lk_spurious_net", 64'(net_phase), 64'(exp_net));
        chk("lk_spurious_steps", 64'(steps_issued), 64'd1);
        chk("lk_ready_still_low", 64'(req_ready), 64'd0);
        chk("lk_psen_count", 64'(psen_cyc_q.size()), 64'd1);
        mmcm_locked = 1'b1;
        #1;
        chk("lk_ready_back", 64'(req_ready), 64'd1);

        // psdone lands on the timeout cycle: success
        resp_dly = 64;
        exp_net = exp_net + 32'd1;
        push_exp(1, exp_net, 1'b0, 1'b0);
        send("co", 1);
        wait_done("co", 150, dc);
        sb_compare("co");
        if (psen_cyc_q.size() == 1)
            chk("co_latency", 64'(dc - psen_cyc_q[0]), 64'd65);
        resp_dly = 12;

        // asynchronous reset mid-request
        send("rs", 3);
        wait_steps("rs", 1, 100);
        chk("rs_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #2;
        chk("rs_busy", 64'(busy), 64'd0);
        chk("rs_psincdec", 64'(psincdec), 64'd0);
        chk("rs_steps", 64'(steps_issued), 64'd0);
        chk("rs_net", 64'(net_phase), 64'd0);
        tick();
        chk("rs_no_done", 64'(done_pulse), 64'd0);
        rst = 1'b0;
        tick();
        chk("rs_ready", 64'(req_ready), 64'd1);
        chk("rs_psen_idle", 64'(psen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
